// File: rtl/logic_capture_addr_gen.sv
// Round-robin DRAM address generator for an 8-lane logic-capture engine.
// Define LA_ADDRGEN_RING_EN to make each lane region circular instead of stopping when it fills.
module logic_capture_addr_gen #(
    parameter logic [28:0] BASE_ADDR    = 29'h0,
    parameter int          REGION_WORDS = 4096,
    parameter int          BURST_LEN    = 32
) (
    input  logic        clk_ram_2x,
    input  logic        rst_n,
    input  logic [47:0] lane_level,
    output logic [7:0]  lane_ack,
    input  logic        capture_flush,
    output logic        addr_wr_en,
    output logic [28:0] addr_wr_data,
    output logic [7:0]  addr_wr_size,
    input  logic        addr_full,
    input  logic        ptr_rd_en,
    input  logic [2:0]  ptr_rd_addr,
    output logic [28:0] ptr_rd_data,
    output logic        flush_complete,
    output logic [7:0]  lane_overflow
);

    localparam logic [28:0] REGION = 29'(REGION_WORDS);
    localparam logic [28:0] BURST  = 29'(BURST_LEN);

    typedef enum logic [2:0] {RUN, ISSUE, WAIT, FLUSH, DONE} state_t;

    state_t      state;
    logic        wait_cnt;
    logic [28:0] wp [8];
    logic [2:0]  rr_ptr;

    logic [5:0]  level [8];
    logic [7:0]  elig;
    logic        grant_vld;
    logic [2:0]  grant;
    logic [2:0]  rr_idx;
    logic [28:0] lvl_g;
    logic [28:0] req_size;
    logic [28:0] room;
    logic [28:0] burst_size;
    logic [28:0] wp_sum;
    logic [28:0] next_wp;
    logic        set_ovf;
    logic        issue_go;

    function automatic logic [28:0] lane_base(input logic [2:0] lane);
        return BASE_ADDR + 29'(lane) * REGION;
    endfunction

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            level[i] = lane_level[6*i +: 6];
            if (state == FLUSH)
                elig[i] = ~lane_overflow[i] && (level[i] != 6'd0);
            else
                elig[i] = ~lane_overflow[i] && (29'(level[i]) >= BURST);
        end
    end

    // First eligible lane at or after rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant     = rr_ptr;
        rr_idx    = rr_ptr;
        for (int k = 0; k < 8; k++) begin
            rr_idx = rr_ptr + 3'(k);
            if (!grant_vld && elig[rr_idx]) begin
                grant_vld = 1'b1;
                grant     = rr_idx;
            end
        end
    end

    // A burst never runs past the end of its lane region.
    always_comb begin
        lvl_g      = 29'(level[grant]);
        req_size   = (state == FLUSH && lvl_g < BURST) ? lvl_g : BURST;
        room       = REGION - wp[grant];
        burst_size = (req_size > room) ? room : req_size;
        wp_sum     = wp[grant] + burst_size;
`ifdef LA_ADDRGEN_RING_EN
        next_wp    = (wp_sum == REGION) ? 29'd0 : wp_sum;
        set_ovf    = 1'b0;
`else
        next_wp    = wp_sum;
        set_ovf    = (wp_sum == REGION);
`endif
        issue_go   = grant_vld && !addr_full &&
                     ((state == RUN && !capture_flush) || state == FLUSH);
    end

    always_ff @(posedge clk_ram_2x or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            wait_cnt       <= 1'b0;
            rr_ptr         <= 3'd0;
            for (int i = 0; i < 8; i++) wp[i] <= '0;
            lane_overflow  <= '0;
            lane_ack       <= '0;
            addr_wr_en     <= 1'b0;
            addr_wr_data   <= '0;
            addr_wr_size   <= '0;
            flush_complete <= 1'b0;
            ptr_rd_data    <= '0;
        end else begin
            addr_wr_en <= 1'b0;
            lane_ack   <= '0;
            if (ptr_rd_en)
                ptr_rd_data <= lane_base(ptr_rd_addr) + wp[ptr_rd_addr];

            case (state)
                RUN: begin
                    if (capture_flush) state <= FLUSH;
                    else if (issue_go) state <= ISSUE;
                end
                FLUSH: begin
                    if (!grant_vld) begin
                        state          <= DONE;
                        flush_complete <= 1'b1;
                    end else if (issue_go) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= 1'b0;
                end
                WAIT: begin
                    if (wait_cnt) state <= capture_flush ? FLUSH : RUN;
                    else wait_cnt <= 1'b1;
                end
                DONE: flush_complete <= 1'b1;
                default: state <= RUN;
            endcase

            // The push is registered on entry to ISSUE so addr_wr_en is high for exactly that cycle.
            if (issue_go) begin
                addr_wr_en   <= 1'b1;
                addr_wr_data <= lane_base(grant) + wp[grant];
                addr_wr_size <= 8'(burst_size);
                lane_ack     <= 8'b1 << grant;
                wp[grant]    <= next_wp;
                rr_ptr       <= grant + 3'd1;
                if (set_ovf) lane_overflow[grant] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_logic_capture_addr_gen.sv
// Directed bench for logic_capture_addr_gen with BASE_ADDR=0, REGION_WORDS=256, BURST_LEN=32.
// Expected pushes are queued as stimulus is applied and popped by a monitor on addr_wr_en.
module tb_logic_capture_addr_gen;

    localparam int W = 45;  // {ack[7:0], size[7:0], addr[28:0]}

    logic        clk_ram_2x;
    logic        rst_n;
    logic [47:0] lane_level;
    logic [7:0]  lane_ack;
    logic        capture_flush;
    logic        addr_wr_en;
    logic [28:0] addr_wr_data;
    logic [7:0]  addr_wr_size;
    logic        addr_full;
    logic        ptr_rd_en;
    logic [2:0]  ptr_rd_addr;
    logic [28:0] ptr_rd_data;
    logic        flush_complete;
    logic [7:0]  lane_overflow;

    logic [W-1:0] exp_q[$];
    int           mwp [8];
    int           n_checks = 0;
    int           n_pass   = 0;

    logic_capture_addr_gen #(
        .BASE_ADDR   (29'h0),
        .REGION_WORDS(256),
        .BURST_LEN   (32)
    ) dut (
        .clk_ram_2x    (clk_ram_2x),
        .rst_n         (rst_n),
        .lane_level    (lane_level),
        .lane_ack      (lane_ack),
        .capture_flush (capture_flush),
        .addr_wr_en    (addr_wr_en),
        .addr_wr_data  (addr_wr_data),
        .addr_wr_size  (addr_wr_size),
        .addr_full     (addr_full),
        .ptr_rd_en     (ptr_rd_en),
        .ptr_rd_addr   (ptr_rd_addr),
        .ptr_rd_data   (ptr_rd_data),
        .flush_complete(flush_complete),
        .lane_overflow (lane_overflow)
    );

    // Clock and reset
    initial clk_ram_2x = 1'b0;
    always #5 clk_ram_2x = ~clk_ram_2x;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        lane_level    = '0;
        capture_flush = 1'b0;
        addr_full     = 1'b0;
        ptr_rd_en     = 1'b0;
        ptr_rd_addr   = 3'd0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) mwp[i] = 0;
        repeat (3) @(negedge clk_ram_2x);
        rst_n = 1'b1;
        @(negedge clk_ram_2x);
    endtask

    // Driver tasks
    task automatic set_level(input int lane, input int val);
        lane_level[6*lane +: 6] = 6'(val);
    endtask

    task automatic exp_push(input int lane, input int size);
        logic [7:0] ack;
        ack = 8'b1 << lane;
        exp_q.push_back({ack, 8'(size), 29'(lane * 256 + mwp[lane])});
`ifdef LA_ADDRGEN_RING_EN
        mwp[lane] = (mwp[lane] + size) % 256;
`else
        mwp[lane] = mwp[lane] + size;
`endif
    endtask

    task automatic wait_push(input int bound);
        int c;
        c = 0;
        do begin
            @(negedge clk_ram_2x);
            c++;
        end while (addr_wr_en !== 1'b1 && c < bound);
        check("push_seen", 64'(addr_wr_en), 64'd1);
    endtask

    task automatic read_ptr(input int lane);
        ptr_rd_addr = 3'(lane);
        ptr_rd_en   = 1'b1;
        @(negedge clk_ram_2x);
        ptr_rd_en   = 1'b0;
    endtask

    // Scoreboard: every push is matched against the head of exp_q
    always @(negedge clk_ram_2x) begin
        if (rst_n) begin
            if (addr_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_push", 64'(addr_wr_data), 64'h1fffffff);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check("push", 64'({lane_ack, addr_wr_size, addr_wr_data}), 64'(e));
                end
            end else if (lane_ack !== 8'h00) begin
                check("ack_without_push", 64'(lane_ack), 64'h0);
            end
        end
    end

    initial begin
        do_reset();

        // Reset state
        check("rst_wr_en",    64'(addr_wr_en),     64'd0);
        check("rst_ack",      64'(lane_ack),       64'd0);
        check("rst_data",     64'(addr_wr_data),   64'd0);
        check("rst_size",     64'(addr_wr_size),   64'd0);
        check("rst_ptr",      64'(ptr_rd_data),    64'd0);
        check("rst_flush",    64'(flush_complete), 64'd0);
        check("rst_overflow", 64'(lane_overflow),  64'd0);

        // Single lane above burst threshold, then level drops below it
        exp_push(2, 32);
        set_level(2, 40);
        wait_push(20);
        set_level(2, 8);
        repeat (20) @(negedge clk_ram_2x);
        check("lane2_drained", 64'(exp_q.size()), 64'd0);

        // Round-robin between lanes 0 and 5
        do_reset();
        exp_push(0, 32); exp_push(5, 32); exp_push(0, 32); exp_push(5, 32);
        set_level(0, 32);
        set_level(5, 32);
        for (int k = 0; k < 4; k++) wait_push(20);
        lane_level = '0;
        repeat (12) @(negedge clk_ram_2x);
        check("rr_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure from the address FIFO
        do_reset();
        addr_full = 1'b1;
        set_level(1, 32);
        exp_push(1, 32);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_ram_2x);
            check("full_no_push", 64'({lane_ack, addr_wr_en}), 64'd0);
        end
        addr_full = 1'b0;
        @(negedge clk_ram_2x);
        check("push_after_full", 64'(addr_wr_en), 64'd1);
        set_level(1, 0);
        repeat (8) @(negedge clk_ram_2x);
        check("full_drained", 64'(exp_q.size()), 64'd0);

        // Pointer readback, hold, and reset
        do_reset();
        exp_push(6, 32); exp_push(6, 32);
        set_level(6, 32);
        wait_push(20);
        wait_push(20);
        set_level(6, 0);
        repeat (4) @(negedge clk_ram_2x);
        read_ptr(6);
        check("ptr_lane6", 64'(ptr_rd_data), 64'h640);
        ptr_rd_addr = 3'd2;
        repeat (3) @(negedge clk_ram_2x);
        check("ptr_hold", 64'(ptr_rd_data), 64'h640);
        do_reset();
        check("ptr_after_rst", 64'(ptr_rd_data), 64'h0);
        read_ptr(6);
        check("ptr_lane6_rst", 64'(ptr_rd_data), 64'h600);

        // Fill lane 3's region
        do_reset();
        set_level(3, 32);
        for (int k = 0; k < 8; k++) exp_push(3, 32);
        for (int k = 0; k < 8; k++) wait_push(20);
`ifdef LA_ADDRGEN_RING_EN
        exp_push(3, 32);
        wait_push(20);
        set_level(3, 0);
        repeat (12) @(negedge clk_ram_2x);
        check("ring_overflow", 64'(lane_overflow), 64'h00);
`else
        repeat (24) @(negedge clk_ram_2x);
        check("region_overflow", 64'(lane_overflow), 64'h08);
        set_level(3, 0);
`endif
        check("fill_drained", 64'(exp_q.size()), 64'd0);

        // Flush of a partial burst
        do_reset();
        set_level(4, 5);
        set_level(7, 0);
        capture_flush = 1'b1;
        exp_push(4, 5);
        wait_push(20);
        set_level(4, 0);
        for (int c = 0; c < 20 && flush_complete !== 1'b1; c++) @(negedge clk_ram_2x);
        check("flush_complete", 64'(flush_complete), 64'd1);
        capture_flush = 1'b0;
        repeat (6) @(negedge clk_ram_2x);
        check("flush_sticky", 64'({flush_complete, addr_wr_en}), 64'h2);
        check("flush_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
